// File: rtl/regfile_write_ctrl.sv
// Write-port controller and read front end for a 32x32 register bank: staged
// writes, post-reset clear sweep, bypassed read ports. Optional REGFILE_WRCOUNT_EN adds Wr_count.
module regfile_write_ctrl #(
  parameter logic [31:0] CLEAR_VALUE    = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Wr_valid,
  output logic          Wr_ready,
  input  logic [4:0]    Wr_addr,
  input  logic [31:0]   Wr_data,
  input  logic [4:0]    Rd_addr1,
  input  logic [4:0]    Rd_addr2,
  output logic [31:0]   Rd_data1,
  output logic [31:0]   Rd_data2,
  output logic          Busy,
  output logic [31:0]   Bank_we,
  output logic [31:0]   Bank_wdata,
  input  logic [1023:0] Bank_q
`ifdef REGFILE_WRCOUNT_EN
  ,
  output logic [15:0]   Wr_count
`endif
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic        pend_valid;
  logic [4:0]  pend_addr;
  logic [31:0] pend_data;
  logic        accept;

  assign accept = Wr_valid && Wr_ready;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      state <= state_next;
      if (state == S_CLEAR) begin
        cnt <= cnt + 5'd1;
      end
      // Writes to register 0 are accepted but never staged.
      pend_valid <= accept && (Wr_addr != 5'd0);
      if (accept) begin
        pend_addr <= Wr_addr;
        pend_data <= Wr_data;
      end
    end
  end

  always_comb begin
    state_next = state;
    Wr_ready   = 1'b0;
    Busy       = 1'b1;
    Bank_we    = '0;
    Bank_wdata = CLEAR_VALUE;
    if (!Rst) begin
      case (state)
        S_CLEAR: begin
          Bank_we = 32'd1 << cnt;
          if (cnt == 5'd31) begin
            state_next = S_RUN;
          end
        end
        S_RUN: begin
          Busy       = 1'b0;
          Wr_ready   = 1'b1;
          Bank_wdata = pend_data;
          if (pend_valid) begin
            Bank_we = 32'd1 << pend_addr;
          end
        end
        default: state_next = S_CLEAR;
      endcase
    end
  end

  // Read priority: reset/addr 0, then clear value, then staged write, then bank.
  always_comb begin
    Rd_data1 = '0;
    if (!Rst && Rd_addr1 != 5'd0) begin
      if (state == S_CLEAR) begin
        Rd_data1 = CLEAR_VALUE;
      end else if (pend_valid && pend_addr == Rd_addr1) begin
        Rd_data1 = pend_data;
      end else begin
        Rd_data1 = Bank_q[{Rd_addr1, 5'd0} +: 32];
      end
    end
  end

  always_comb begin
    Rd_data2 = '0;
    if (!Rst && Rd_addr2 != 5'd0) begin
      if (state == S_CLEAR) begin
        Rd_data2 = CLEAR_VALUE;
      end else if (pend_valid && pend_addr == Rd_addr2) begin
        Rd_data2 = pend_data;
      end else begin
        Rd_data2 = Bank_q[{Rd_addr2, 5'd0} +: 32];
      end
    end
  end

`ifdef REGFILE_WRCOUNT_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Wr_count <= '0;
    end else if (accept && Wr_addr != 5'd0 && Wr_count != 16'hFFFF) begin
      Wr_count <= Wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Self-checking bench for regfile_write_ctrl: bank model, per-cycle reference
// model of the register file's visible contents, and directed scenarios.
module tb_regfile_write_ctrl;

  localparam logic [31:0] CV = 32'h0000_0000;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Wr_valid = 1'b0;
  logic          Wr_ready;
  logic [4:0]    Wr_addr = '0;
  logic [31:0]   Wr_data = '0;
  logic [4:0]    Rd_addr1 = '0;
  logic [4:0]    Rd_addr2 = '0;
  logic [31:0]   Rd_data1, Rd_data2;
  logic          Busy;
  logic [31:0]   Bank_we, Bank_wdata;
  logic [1023:0] Bank_q;
`ifdef REGFILE_WRCOUNT_EN
  logic [15:0]   Wr_count;
`endif

  regfile_write_ctrl #(.CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .Wr_valid(Wr_valid), .Wr_ready(Wr_ready),
    .Wr_addr(Wr_addr), .Wr_data(Wr_data), .Rd_addr1(Rd_addr1), .Rd_addr2(Rd_addr2),
    .Rd_data1(Rd_data1), .Rd_data2(Rd_data2), .Busy(Busy), .Bank_we(Bank_we),
    .Bank_wdata(Bank_wdata), .Bank_q(Bank_q)
`ifdef REGFILE_WRCOUNT_EN
    , .Wr_count(Wr_count)
`endif
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Register bank: nonzero power-up contents so the clear sweep is visible.
  logic [31:0] bank [32];
  initial begin
    for (int i = 0; i < 32; i++) bank[i] = 32'h5A5A_0000 | (32'h0101_0101 * i) | 32'h1;
  end
  always @(posedge Clk) begin
    for (int i = 0; i < 32; i++) if (Bank_we[i]) bank[i] <= Bank_wdata;
  end
  always_comb begin
    Bank_q = '0;
    for (int unsigned i = 0; i < 32; i++) Bank_q[i*32 +: 32] = bank[i];
  end

  // Reference model: what the register file must look like to a reader.
  bit          m_init = 0;
  int          clear_left = 0;
  bit          m_pend = 0;
  logic [4:0]  m_pend_addr = '0;
  logic [31:0] m_pend_data = '0;
  logic [31:0] m_regs [32];
  int          m_count = 0;

  always @(posedge Clk) begin
    if (Rst) begin
      m_init = 1;
      clear_left = 32;
      m_pend = 0;
      m_count = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = CV;
    end else if (m_init) begin
      if (clear_left > 0) begin
        clear_left--;
        m_pend = 0;
      end else if (Wr_valid && Wr_addr != 5'd0) begin
        m_regs[Wr_addr] = Wr_data;
        m_pend = 1;
        m_pend_addr = Wr_addr;
        m_pend_data = Wr_data;
        if (m_count < 65535) m_count++;
      end else begin
        m_pend = 0;
      end
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (clear_left > 0) return CV;
    return m_regs[a];
  endfunction

  always @(negedge Clk) begin
    if (m_init) begin
      if (Rst) begin
        check("rst_we", Bank_we, 0);
        check("rst_ready", Wr_ready, 0);
        check("rst_busy", Busy, 1);
        check("rst_rd1", Rd_data1, 0);
        check("rst_rd2", Rd_data2, 0);
      end else begin
        check("m_busy", Busy, clear_left > 0);
        check("m_ready", Wr_ready, clear_left == 0);
        if (clear_left > 0) begin
          check("m_we_clear", Bank_we, 64'd1 << (32 - clear_left));
          check("m_wdata_clear", Bank_wdata, CV);
        end else begin
          check("m_we_run", Bank_we, m_pend ? (64'd1 << m_pend_addr) : 64'd0);
          if (m_pend) check("m_wdata_run", Bank_wdata, m_pend_data);
        end
        check("m_rd1", Rd_data1, exp_read(Rd_addr1));
        check("m_rd2", Rd_data2, exp_read(Rd_addr2));
`ifdef REGFILE_WRCOUNT_EN
        check("m_count", Wr_count, m_count);
`endif
      end
    end
  end

  bit watch9 = 0;
  bit bad9 = 0;
  always @(negedge Clk) if (watch9 && bank[9] == 32'h1234_5678) bad9 = 1;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  int busy_cycles;

  initial begin
    // 1: reset, then the 32-cycle sweep
    step();
    step();
    Rst = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (!Busy) break;
      busy_cycles++;
      if (i < 32) check("sweep_we", Bank_we, 64'd1 << i);
      step();
    end
    check("busy_cycles", busy_cycles, 32);
    check("ready_after", Wr_ready, 1);
    check("bank31_cleared", bank[31], 32'h0);
    check("bank0_cleared", bank[0], 32'h0);

    // 2: write 5 = DEADBEEF, bypass then bank
    Rd_addr1 = 5'd5;
    Wr_valid = 1'b1; Wr_addr = 5'd5; Wr_data = 32'hDEAD_BEEF;
    step();
    Wr_valid = 1'b0;
    @(negedge Clk);
    check("t2_bypass", Rd_data1, 32'hDEAD_BEEF);
    check("t2_we", Bank_we, 32'h20);
    step();
    @(negedge Clk);
    check("t2_bank_read", Rd_data1, 32'hDEAD_BEEF);
    check("t2_bank5", bank[5], 32'hDEAD_BEEF);
    check("t2_we_idle", Bank_we, 0);

    // 3: write to register 0 is dropped
    Rd_addr1 = 5'd0;
    Wr_valid = 1'b1; Wr_addr = 5'd0; Wr_data = 32'hFFFF_FFFF;
    step();
    Wr_valid = 1'b0;
    @(negedge Clk);
    check("t3_we", Bank_we, 0);
    check("t3_rd0", Rd_data1, 0);
`ifdef REGFILE_WRCOUNT_EN
    check("t3_count", Wr_count, 1);
`endif

    // 4: back-to-back writes to 7
    Rd_addr2 = 5'd7;
    Wr_valid = 1'b1; Wr_addr = 5'd7; Wr_data = 32'd1;
    step();
    Wr_data = 32'd2;
    @(negedge Clk);
    check("t4_rd_1", Rd_data2, 1);
    step();
    Wr_data = 32'd3;
    @(negedge Clk);
    check("t4_rd_2", Rd_data2, 2);
    step();
    Wr_valid = 1'b0;
    @(negedge Clk);
    check("t4_rd_3", Rd_data2, 3);
    step();
    @(negedge Clk);
    check("t4_bank7", bank[7], 3);

    // 5: reset while a write to 9 is staged
    Rd_addr1 = 5'd9;
    Wr_valid = 1'b1; Wr_addr = 5'd9; Wr_data = 32'h1234_5678;
    step();
    Wr_valid = 1'b0;
    Rst = 1'b1;
    watch9 = 1;
    @(negedge Clk);
    check("t5_we_rst", Bank_we, 0);
    step();
    Rst = 1'b0;
    @(negedge Clk);
    check("t5_restart", Bank_we, 1);
    for (int i = 0; i < 32; i++) step();
    @(negedge Clk);
    check("t5_busy_done", Busy, 0);
    check("t5_rd9", Rd_data1, CV);
    check("t5_no_stale", bad9, 0);
    watch9 = 0;

`ifdef REGFILE_WRCOUNT_EN
    // 6: saturation
    Wr_valid = 1'b1; Wr_addr = 5'd1;
    for (int i = 0; i < 65535; i++) begin
      Wr_data = i;
      step();
    end
    Wr_valid = 1'b0;
    @(negedge Clk);
    check("t6_preload", Wr_count, 16'hFFFF);
    Wr_valid = 1'b1;
    step();
    step();
    Wr_valid = 1'b0;
    @(negedge Clk);
    check("t6_saturate", Wr_count, 16'hFFFF);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
